cam_cfg_sequencer: RTL and testbench
====================================

// Module: cam_cfg_sequencer
// PURPOSE
//  Walks the OV7670 register-config ROM and issues each (reg_addr, reg_data) write to a byte-level
//  SCCB master through a start/done handshake. Adds three things to the init path: timed delay entries
//  (e.g. after the 0x12=0x80 soft reset), NACK retry and an end-of-table marker. Sits between the
//  top-level camera bring-up control and the SCCB master; exposes busy/done/error status to the top.
// PARAMETERS
//  ROM_AW            8      ROM address width; table depth = 2**ROM_AW entries
//  DELAY_UNIT_CYCLES 24000  xclk cycles per delay unit (1 ms at 24 MHz xclk)
//  MAX_RETRY         3      re-issues of a NACKed entry before declaring error
// PORTS
//  xclk           in   1      clock
//  reset          in   1      synchronous, active-high reset
//  start          in   1      begin the sequence from entry 0 (sampled in IDLE/DONE/ERROR only)
//  rom_addr       out  ROM_AW ROM read address (registered)
//  rom_dout       in   16     ROM data {reg_addr[15:8], reg_data[7:0]}; sync ROM, 1-cycle latency
//  sccb_ready     in   1      SCCB master idle and able to accept a transaction
//  sccb_start     out  1      one-cycle pulse launching a 3-phase write (0x42, reg_addr, reg_data)
//  sccb_reg_addr  out  8      register address; stable from DECODE until sccb_done
//  sccb_reg_data  out  8      register data; stable from DECODE until sccb_done
//  sccb_done      in   1      one-cycle pulse: transaction finished (STOP sent)
//  sccb_nack      in   1      valid with sccb_done: 1 = any byte was NACKed
//  busy           out  1      high from the cycle after start is accepted until DONE/ERROR
//  cfg_done       out  1      sticky: table completed; cleared by next accepted start
//  cfg_error      out  1      sticky: retries exhausted; cleared by next accepted start
// BEHAVIOUR
//  Reset: state IDLE, rom_addr=0, sccb_start=0, sccb_reg_addr/data=0, busy=0, cfg_done=0, cfg_error=0,
//   retry_cnt=0, delay counters=0. Reset mid-transaction abandons it at once; no sccb_start is issued.
//  Entry decode (in DECODE): 16'hFFFF = end marker; {8'hFF, n}, n!=FF = delay n units, no SCCB access;
//   anything else = register write.
//  FSM:
//   IDLE/DONE/ERROR --start--> FETCH  (rom_addr<=0, retry_cnt<=0, clear done/error, busy<=1)
//   FETCH (1 cycle, ROM samples rom_addr) -> DECODE (rom_dout valid)
//   DECODE: end -> DONE; delay n=0 -> NEXT; delay n>0 -> DELAY; write -> latch addr/data, -> ISSUE
//   ISSUE: wait while sccb_ready=0; when sccb_ready=1, pulse sccb_start 1 cycle -> WAIT_DONE
//   WAIT_DONE: on sccb_done & !nack -> NEXT (retry_cnt<=0);
//    on sccb_done & nack: retry_cnt<MAX_RETRY -> retry_cnt++, -> ISSUE (same entry); else -> ERROR
//   DELAY: unit counter 0..DELAY_UNIT_CYCLES-1; unit count 0..n-1; after exactly n*DELAY_UNIT_CYCLES
//    cycles -> NEXT
//   NEXT: rom_addr==2**ROM_AW-1 -> DONE (no wrap, missing marker tolerated); else rom_addr++ -> FETCH
//  Latency: start accepted at edge k -> FETCH in cycle k+1; first sccb_start no earlier than cycle k+4.
//  cfg_done / cfg_error: set on entering DONE / ERROR; busy drops in the same cycle. They are
//   mutually exclusive.
//  start while busy is ignored. sccb_done outside WAIT_DONE is ignored. sccb_start never asserts
//   in 2 consecutive cycles.
//  sccb_nack is sampled only in the cycle sccb_done=1.
//  retry_cnt width $clog2(MAX_RETRY+1); total issues per entry <= MAX_RETRY+1.
// TESTING
//  1 ROM {1280,1101,0C00,FFFF}, start -> 3 sccb_start pulses carrying (12,80),(11,01),(0C,00);
//    then cfg_done=1, busy=0, no 4th start.
//  2 DELAY_UNIT_CYCLES=10, ROM {1280,FF05,1101,FFFF} -> exactly 50 DELAY cycles between done of
//    entry0 and FETCH of entry2.
//  3 MAX_RETRY=3: NACK 3x then ACK on entry0 -> 4 starts with identical addr/data, then proceeds.
//    NACK 4x -> cfg_error=1, cfg_done=0.
//  4 sccb_ready held 0 for 20 cycles while in ISSUE -> sccb_start stays 0; fires 1 cycle after
//    ready rises.
//  5 reset asserted in WAIT_DONE -> all outputs at reset values next cycle; a new start begins at
//    rom_addr 0.
//  6 start pulsed mid-sequence -> ignored; ROM with no FFFF (ROM_AW=2) -> 4 writes then cfg_done,
//    rom_addr ends at 3.

Source files
------------

// File: rtl/cam_cfg_sequencer_if.sv
// SCCB byte-master handshake between the config sequencer
// and the SCCB master.
interface cam_cfg_sequencer_if;
    logic       sccb_ready;
    logic       sccb_start;
    logic [7:0] sccb_reg_addr;
    logic [7:0] sccb_reg_data;
    logic       sccb_done;
    logic       sccb_nack;

    modport master (
        input  sccb_ready,
        input  sccb_done,
        input  sccb_nack,
        output sccb_start,
        output sccb_reg_addr,
        output sccb_reg_data
    );

    modport slave (
        output sccb_ready,
        output sccb_done,
        output sccb_nack,
        input  sccb_start,
        input  sccb_reg_addr,
        input  sccb_reg_data
    );
endinterface

// File: rtl/cam_cfg_sequencer.sv
// OV7670 config ROM walker: issues SCCB register writes with
// timed delay entries, NACK retry and end-of-table marker.
module cam_cfg_sequencer #(
    parameter int ROM_AW            = 8,
    parameter int DELAY_UNIT_CYCLES = 24000,
    parameter int MAX_RETRY         = 3
) (
    input  logic                xclk,
    input  logic                reset,
    input  logic                start,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [15:0]         rom_dout,
    cam_cfg_sequencer_if.master sccb,
    output logic                busy,
    output logic                cfg_done,
    output logic                cfg_error
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int UW = (DELAY_UNIT_CYCLES > 1) ?
                        $clog2(DELAY_UNIT_CYCLES) : 1;
    localparam logic [ROM_AW-1:0] LAST_ADDR = '1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(DELAY_UNIT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT,
        S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t state, state_nxt;

    logic [RW-1:0] retry_cnt;
    logic [UW-1:0] unit_cnt;
    logic [7:0]    unit_idx;
    logic [7:0]    delay_n;

    logic is_end, is_wr, is_dly0, is_dlyn;
    logic accept, unit_wrap, delay_last;

    // 0xFF in the address byte marks a non-SCCB entry
    assign is_wr      = rom_dout[15:8] != 8'hFF;
    assign is_end     = rom_dout == 16'hFFFF;
    assign is_dly0    = !is_wr && rom_dout[7:0] == 8'h00;
    assign is_dlyn    = !is_wr && !is_end && rom_dout[7:0] != 8'h00;
    assign unit_wrap  = unit_cnt == UNIT_LAST;
    assign delay_last = unit_idx == delay_n - 8'd1;
    assign accept     = start && (state == S_IDLE || state == S_DONE ||
                                  state == S_ERROR);

    always_ff @(posedge xclk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (start) state_nxt = S_FETCH;
            S_FETCH:
                state_nxt = S_DECODE;
            S_DECODE:
                unique case (1'b1)
                    is_end:  state_nxt = S_DONE;
                    is_dly0: state_nxt = S_NEXT;
                    is_dlyn: state_nxt = S_DELAY;
                    is_wr:   state_nxt = S_ISSUE;
                    default: state_nxt = S_NEXT;
                endcase
            S_ISSUE:
                if (sccb.sccb_ready) state_nxt = S_WAIT;
            S_WAIT:
                if (sccb.sccb_done) begin
                    if (!sccb.sccb_nack)          state_nxt = S_NEXT;
                    else if (retry_cnt < RETRY_MAX) state_nxt = S_ISSUE;
                    else                          state_nxt = S_ERROR;
                end
            S_DELAY:
                if (unit_wrap && delay_last) state_nxt = S_NEXT;
            S_NEXT:
                state_nxt = (rom_addr == LAST_ADDR) ? S_DONE : S_FETCH;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge xclk) begin
        if (reset) begin
            rom_addr           <= '0;
            sccb.sccb_start    <= 1'b0;
            sccb.sccb_reg_addr <= 8'h00;
            sccb.sccb_reg_data <= 8'h00;
            busy               <= 1'b0;
            cfg_done           <= 1'b0;
            cfg_error          <= 1'b0;
            retry_cnt          <= '0;
            unit_cnt           <= '0;
            unit_idx           <= 8'd0;
            delay_n            <= 8'd0;
        end else begin
            sccb.sccb_start <= 1'b0;
            if (accept) begin
                rom_addr  <= '0;
                retry_cnt <= '0;
                cfg_done  <= 1'b0;
                cfg_error <= 1'b0;
                busy      <= 1'b1;
            end
            if (state == S_DECODE && is_wr) begin
                sccb.sccb_reg_addr <= rom_dout[15:8];
                sccb.sccb_reg_data <= rom_dout[7:0];
            end
            if (state == S_DECODE && is_dlyn) begin
                delay_n  <= rom_dout[7:0];
                unit_cnt <= '0;
                unit_idx <= 8'd0;
            end
            if (state == S_ISSUE && sccb.sccb_ready)
                sccb.sccb_start <= 1'b1;
            if (state == S_WAIT && sccb.sccb_done) begin
                if (!sccb.sccb_nack)
                    retry_cnt <= '0;
                else if (retry_cnt < RETRY_MAX)
                    retry_cnt <= retry_cnt + RW'(1);
            end
            if (state == S_DELAY) begin
                if (unit_wrap) begin
                    unit_cnt <= '0;
                    unit_idx <= unit_idx + 8'd1;
                end else begin
                    unit_cnt <= unit_cnt + UW'(1);
                end
            end
            if (state == S_NEXT && rom_addr != LAST_ADDR)
                rom_addr <= rom_addr + ROM_AW'(1);
            if (state_nxt == S_DONE && state != S_DONE) begin
                busy     <= 1'b0;
                cfg_done <= 1'b1;
            end
            if (state_nxt == S_ERROR && state != S_ERROR) begin
                busy      <= 1'b0;
                cfg_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: vector table, timing corners and
// random ROM/NACK runs against a table-walking reference model.
module tb_cam_cfg_sequencer;

    localparam int AW = 2;
    localparam int DU = 10;
    localparam int MR = 3;

    logic          xclk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_dout;
    logic          busy, cfg_done, cfg_error;

    cam_cfg_sequencer_if bus();

    cam_cfg_sequencer #(
        .ROM_AW(AW), .DELAY_UNIT_CYCLES(DU), .MAX_RETRY(MR)
    ) dut (
        .xclk(xclk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_dout(rom_dout),
        .sccb(bus.master),
        .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
    );

    always #5 xclk = ~xclk;

    logic [15:0] rom [4];
    always @(posedge xclk) rom_dout <= rom[rom_addr];

    int cyc = 0;
    always @(posedge xclk) cyc <= cyc + 1;

    // SCCB master model; also watches protocol rules
    logic [63:0] nk_bits = '0;
    int          nk_base = 0;
    int          txn = 0;
    int          lat = 3;
    bit          hold_low = 0;
    bit          mute = 0;
    bit          sl_busy = 0;
    bit          cur_nk = 0;
    bit          prev_start = 0;
    int          sl_cnt = 0;
    int          viol = 0;
    logic [15:0] cur_w = '0;
    logic [15:0] wr_q[$];
    int          st_q[$];
    int          dn_q[$];

    always @(negedge xclk) begin
        int k;
        bus.sccb_done = 1'b0;
        bus.sccb_nack = 1'b0;
        if (bus.sccb_start === 1'b1 && prev_start) viol++;
        if (cfg_done === 1'b1 && cfg_error === 1'b1) viol++;
        prev_start = (bus.sccb_start === 1'b1);
        if (reset === 1'b1) begin
            sl_busy = 0;
        end else if (bus.sccb_start === 1'b1) begin
            if (sl_busy) viol++;
            cur_w = {bus.sccb_reg_addr, bus.sccb_reg_data};
            wr_q.push_back(cur_w);
            st_q.push_back(cyc);
            k = txn - nk_base;
            cur_nk = (k >= 0 && k < 64) ? nk_bits[k[5:0]] : 1'b0;
            txn++;
            sl_busy = 1;
            sl_cnt = lat;
        end else if (sl_busy) begin
            if ({bus.sccb_reg_addr, bus.sccb_reg_data} !== cur_w) viol++;
            if (!mute) begin
                if (sl_cnt == 0) begin
                    bus.sccb_done = 1'b1;
                    bus.sccb_nack = cur_nk;
                    sl_busy = 0;
                    dn_q.push_back(cyc);
                end else begin
                    sl_cnt--;
                end
            end
        end
        bus.sccb_ready = !sl_busy && !hold_low;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int wb, sb, db;

    task automatic mark();
        nk_base = txn;
        wb = wr_q.size();
        sb = st_q.size();
        db = dn_q.size();
    endtask

    task automatic wait_idle(output bit to);
        int n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge xclk);
            n++;
        end
        to = (busy !== 1'b0);
    endtask

    task automatic run(input bit mid, output bit to);
        int n = 0;
        mark();
        @(negedge xclk); start = 1'b1;
        @(negedge xclk); start = 1'b0;
        if (mid) begin
            while (wr_q.size() == wb && n < 200) begin
                @(negedge xclk);
                n++;
            end
            start = 1'b1;
            @(negedge xclk); start = 1'b0;
        end
        wait_idle(to);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_sccb_start"}, 32'(bus.sccb_start), 0);
        chk({tag, "_reg_addr"}, 32'(bus.sccb_reg_addr), 0);
        chk({tag, "_reg_data"}, 32'(bus.sccb_reg_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cfg_done"}, 32'(cfg_done), 0);
        chk({tag, "_cfg_error"}, 32'(cfg_error), 0);
    endtask

    // reference: walk the table entry by entry
    logic [15:0] exp_q[$];
    bit          exp_done, exp_err;
    int          exp_addr;

    task automatic model_run();
        int t = 0;
        exp_q.delete();
        exp_done = 0;
        exp_err = 0;
        exp_addr = 0;
        for (int i = 0; i < 4; i++) begin
            int  tries;
            bit  ok;
            exp_addr = i;
            if (rom[i] == 16'hFFFF) begin
                exp_done = 1;
                return;
            end
            if (rom[i][15:8] != 8'hFF) begin
                tries = 0;
                ok = 0;
                while (!ok && tries < MR + 1) begin
                    exp_q.push_back(rom[i]);
                    ok = !nk_bits[t];
                    t++;
                    tries++;
                end
                if (!ok) begin
                    exp_err = 1;
                    return;
                end
            end
        end
        exp_done = 1;
    endtask

    typedef struct {
        logic [15:0] r0, r1, r2, r3;
        logic [15:0] nk;
        int          starts;
        bit          dn, er;
        int          addr;
        logic [15:0] first, last;
    } vec_t;

    vec_t vt[8];

    initial begin
        bit to;
        int k, n, cnt;
        vt[0] = '{16'h1280, 16'h1101, 16'h0C00, 16'hFFFF, 16'h0000,
                  3, 1'b1, 1'b0, 3, 16'h1280, 16'h0C00};
        vt[1] = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 16'h0007,
                  5, 1'b1, 1'b0, 2, 16'h1280, 16'h1101};
        vt[2] = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 16'h000F,
                  4, 1'b0, 1'b1, 0, 16'h1280, 16'h1280};
        vt[3] = '{16'h1280, 16'h1101, 16'h0C00, 16'h3A04, 16'h0000,
                  4, 1'b1, 1'b0, 3, 16'h1280, 16'h3A04};
        vt[4] = '{16'hFF00, 16'h1101, 16'hFFFF, 16'h0000, 16'h0000,
                  1, 1'b1, 1'b0, 2, 16'h1101, 16'h1101};
        vt[5] = '{16'hFFFF, 16'h1234, 16'h1234, 16'h1234, 16'h0000,
                  0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000};
        vt[6] = '{16'h1280, 16'h1101, 16'h0C00, 16'hFFFF, 16'h0006,
                  5, 1'b1, 1'b0, 3, 16'h1280, 16'h0C00};
        vt[7] = '{16'hFF01, 16'hFF02, 16'h2233, 16'h4455, 16'h0000,
                  2, 1'b1, 1'b0, 3, 16'h2233, 16'h4455};

        reset = 1'b1;
        start = 1'b0;
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        rom[2] = 16'h0C00; rom[3] = 16'hFFFF;
        repeat (3) @(negedge xclk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge xclk);

        // start acceptance latency and back-to-back write spacing
        mark();
        start = 1'b1;
        @(negedge xclk); start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        k = 1;
        while (bus.sccb_start !== 1'b1 && k < 20) begin
            @(negedge xclk);
            k++;
        end
        chk("first_start_latency", k, 4);
        wait_idle(to);
        chk("lat_timeout", 32'(to), 0);
        chk("lat_starts", wr_q.size() - wb, 3);
        chk("lat_done", 32'(cfg_done), 1);
        if (st_q.size() - sb == 3 && dn_q.size() - db >= 2) begin
            chk("gap_w0_w1", st_q[sb+1] - dn_q[db], 5);
            chk("gap_w1_w2", st_q[sb+2] - dn_q[db+1], 5);
        end
        repeat (5) @(negedge xclk);
        chk("no_4th_start", wr_q.size() - wb, 3);

        for (int i = 0; i < 8; i++) begin
            rom[0] = vt[i].r0; rom[1] = vt[i].r1;
            rom[2] = vt[i].r2; rom[3] = vt[i].r3;
            nk_bits = {48'h0, vt[i].nk};
            run(0, to);
            n = wr_q.size() - wb;
            chk($sformatf("v%0d_timeout", i), 32'(to), 0);
            chk($sformatf("v%0d_starts", i), n, vt[i].starts);
            chk($sformatf("v%0d_done", i), 32'(cfg_done), 32'(vt[i].dn));
            chk($sformatf("v%0d_error", i), 32'(cfg_error), 32'(vt[i].er));
            chk($sformatf("v%0d_rom_addr", i), 32'(rom_addr), vt[i].addr);
            chk($sformatf("v%0d_busy", i), 32'(busy), 0);
            if (n > 0 && vt[i].starts > 0) begin
                chk($sformatf("v%0d_first", i), 32'(wr_q[wb]), 32'(vt[i].first));
                chk($sformatf("v%0d_last", i), 32'(wr_q[wb+n-1]), 32'(vt[i].last));
            end
        end
        nk_bits = '0;

        // 5-unit delay entry between two writes
        rom[0] = 16'h1280; rom[1] = 16'hFF05;
        rom[2] = 16'h1101; rom[3] = 16'hFFFF;
        run(0, to);
        chk("dly_timeout", 32'(to), 0);
        chk("dly_starts", wr_q.size() - wb, 2);
        if (st_q.size() - sb == 2 && dn_q.size() - db >= 1)
            chk("dly_gap", st_q[sb+1] - dn_q[db], 8 + 5 * DU);
        chk("dly_done", 32'(cfg_done), 1);

        // sccb_ready held low while ISSUE waits
        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
        hold_low = 1;
        mark();
        @(negedge xclk); start = 1'b1;
        @(negedge xclk); start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 23; i++) begin
            @(negedge xclk);
            if (bus.sccb_start === 1'b1) cnt++;
        end
        chk("hold_no_start", cnt, 0);
        chk("hold_busy", 32'(busy), 1);
        @(posedge xclk); #1 hold_low = 0;
        @(negedge xclk);
        chk("hold_start_same_cycle", 32'(bus.sccb_start), 0);
        @(negedge xclk);
        chk("hold_start_next_cycle", 32'(bus.sccb_start), 1);
        wait_idle(to);
        chk("hold_done", 32'(cfg_done), 1);

        // reset while waiting for sccb_done
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        rom[2] = 16'h0C00; rom[3] = 16'hFFFF;
        mute = 1;
        mark();
        @(negedge xclk); start = 1'b1;
        @(negedge xclk); start = 1'b0;
        n = 0;
        while (wr_q.size() == wb && n < 50) begin
            @(negedge xclk);
            n++;
        end
        chk("rst_reached_wait", wr_q.size() - wb, 1);
        repeat (2) @(negedge xclk);
        reset = 1'b1;
        @(negedge xclk);
        chk_reset_vals("midrst");
        @(negedge xclk);
        reset = 1'b0;
        mute = 0;
        repeat (3) @(negedge xclk);
        chk("midrst_no_start", wr_q.size() - wb, 1);
        run(0, to);
        chk("midrst_starts", wr_q.size() - wb, 3);
        if (wr_q.size() > wb)
            chk("midrst_first", 32'(wr_q[wb]), 32'h1280);
        chk("midrst_done", 32'(cfg_done), 1);

        // start pulsed mid-sequence is ignored
        run(1, to);
        chk("mid_start_starts", wr_q.size() - wb, 3);
        chk("mid_start_done", 32'(cfg_done), 1);
        chk("mid_start_addr", 32'(rom_addr), 3);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4; i++) begin
                k = $urandom_range(0, 9);
                if (k == 0)
                    rom[i] = 16'hFFFF;
                else if (k <= 2)
                    rom[i] = {8'hFF, 8'($urandom_range(0, 3))};
                else
                    rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
            end
            for (int i = 0; i < 64; i++)
                nk_bits[i] = ($urandom_range(0, 3) == 0);
            lat = $urandom_range(0, 4);
            model_run();
            run(0, to);
            n = wr_q.size() - wb;
            chk($sformatf("r%0d_timeout", it), 32'(to), 0);
            chk($sformatf("r%0d_starts", it), n, exp_q.size());
            for (int j = 0; j < n && j < exp_q.size(); j++)
                chk($sformatf("r%0d_w%0d", it, j), 32'(wr_q[wb+j]), 32'(exp_q[j]));
            chk($sformatf("r%0d_done", it), 32'(cfg_done), 32'(exp_done));
            chk($sformatf("r%0d_error", it), 32'(cfg_error), 32'(exp_err));
            chk($sformatf("r%0d_addr", it), 32'(rom_addr), exp_addr);
        end

        chk("protocol_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
